noc_out_arbiter: RTL and testbench
==================================

Name: noc_out_arbiter

Overview:
- Wormhole output-port arbiter for the NoC switch. Shares one output link among N_IN input flit FIFOs using round-robin packet-level arbitration.
- Pops flits from the winning FIFO through that FIFO's read enable and forwards them to the output.
- Locks the grant until the packet's tail flit has been forwarded.
- Flow control toward the downstream buffer is credit-based.

Parameters:
- N_IN, 4, number of input FIFOs competing for this output.
- FLIT_W, 37, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type.
- CREDITS, 7, initial credit count, equal to the usable depth of the downstream FIFO.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_empty  in  N_IN  empty flag per input FIFO
- in_flit  in  N_IN*FLIT_W  FIFO data_out buses, flattened; input i occupies [i*FLIT_W +: FLIT_W]
- in_rd_en  out  N_IN  one-hot read enable per FIFO; FIFO data is valid the following cycle
- out_valid  out  1  out_flit is valid this cycle
- out_flit  out  FLIT_W  forwarded flit
- out_src  out  $clog2(N_IN)  input index of out_flit
- credit_in  in  1  one-cycle pulse: downstream freed one slot
- grant_active  out  1  arbiter is in LOCKED
- err_credit_ovf  out  1  sticky: credit_in arrived with credits already equal to CREDITS
- err_proto  out  1  sticky: head flit forwarded while a packet was open, or body/tail flit forwarded as the first flit of a grant

Behaviour:
- Flit type encoding: 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL (single-flit packet).
- Reset, asynchronous: state=IDLE, rr_ptr=0, lock_id=0, credits=CREDITS, out_valid=0, out_src=0, in_rd_en=0, grant_active=0, both error flags=0. Reset mid-packet abandons the packet; no flit is emitted after reset deasserts until a new grant.
- Read latency: in_rd_en[i] at cycle t gives out_valid=1 at t+1.
  - out_flit at t+1 is a combinational mux of in_flit[src_q], where src_q is the registered index read at t.
  - out_src = src_q.
- Hard rule: in_rd_en[i] is never asserted when in_empty[i]=1 or credits==0. The FIFO does not guard underflow.
- Credits:
  - Decrement when any in_rd_en is asserted; increment on credit_in; both in the same cycle leave the count unchanged.
  - credit_in at CREDITS saturates the count and sets err_credit_ovf.
  - Counter width is $clog2(CREDITS+1).
- FSM, IDLE:
  - Requesters are inputs with !in_empty. If any requester exists and credits>0, grant the first requester at or after rr_ptr (wrapping modulo N_IN).
  - Same cycle: assert in_rd_en[winner], lock_id<=winner, rr_ptr<=(winner+1) mod N_IN, go to LOCKED.
  - No requester or credits==0: stay in IDLE with no read.
- FSM, LOCKED:
  - release = out_valid && out_src==lock_id && type(out_flit) in {TAIL, HEAD_TAIL}.
  - If release: in_rd_en=0 and go to IDLE. The release cycle is a one-cycle bubble before the next arbitration.
  - Otherwise: in_rd_en[lock_id] = !in_empty[lock_id] && credits>0.
  - This gating gives back-to-back throughput of one flit per cycle and prevents reading past the tail.
  - If the locked FIFO goes empty mid-packet, hold LOCKED and the grant; other inputs wait with no timeout.
- Fairness: rr_ptr advances only at grant, so a requester waits at most N_IN-1 packets.
- Error flags:
  - err_proto is checked only on out_valid cycles, using a registered "first flit of grant" bit. Forwarding is unaffected.
  - Both flags clear only on rst.

Decomposition:
- Package noc_pkg: FLIT_W, the flit type typedef enum (BODY, HEAD, TAIL, HEAD_TAIL), the type-field slice helper function, and the arbiter state enum {IDLE, LOCKED}.
- Sub-module rr_arbiter: N-way round-robin pick from req vector and pointer; produces a one-hot grant and a valid. Purely combinational, instantiated once.

Test Plan:
- Single-flit packet:
  - Stimulus: input 2 holds HEAD_TAIL, others empty.
  - Response: in_rd_en=0100 at t; out_valid, out_src=2 at t+1; FSM in IDLE at t+2; credits=6.
- Round-robin with 3-flit packets:
  - Stimulus: inputs 0, 1 and 3 each hold HEAD, BODY, TAIL.
  - Response: output order is src 0,0,0, then 1,1,1, then 3,3,3 back-to-back within each packet, with one bubble between packets; rr_ptr=0 at end.
- Credit stall:
  - Stimulus: CREDITS=7, no credit_in, input 0 holds a 10-flit packet.
  - Response: exactly 7 flits forwarded, then in_rd_en stays 0.
  - Follow-up: 3 credit_in pulses → 3 more flits forwarded, tail releases.
- Mid-packet empty:
  - Stimulus: input 1 sends HEAD, its FIFO goes empty for 5 cycles while input 0 requests, then BODY, TAIL arrive.
  - Response: input 0 is not granted until input 1's tail has been forwarded; grant_active stays 1 throughout.
- Simultaneous credit events:
  - Stimulus: credit_in on the same cycle as a read → credits unchanged.
  - Stimulus: credit_in at credits=7 → credits stay 7, err_credit_ovf=1.
- Reset and protocol error:
  - Stimulus: rst asserted mid-packet.
  - Response: all outputs are 0 immediately, credits=7 after reset.
  - Stimulus: a BODY flit as the first flit of a grant.
  - Response: err_proto=1.

Source files
------------

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared types for the NoC switch output-port arbiter.
//   FLIT_W       : flit width; the two MSBs carry the flit type
//   flit_type_e  : BODY / HEAD / TAIL / HEAD_TAIL encoding of the type field
//   arb_state_e  : arbiter FSM states (IDLE, LOCKED)
//   flit_type()  : extracts the type field from a flit
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W = 37;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_W-1:FLIT_W-2]);
  endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_out_arbiter_if
// Bundles the input-FIFO side, output link and status signals of one output
// port arbiter.
//   in_empty   : per-FIFO empty flags
//   in_flit    : flattened FIFO data_out buses, input i at [i*FLIT_W +: FLIT_W]
//   in_rd_en   : one-hot FIFO read enables (data valid the next cycle)
//   out_valid  : out_flit / out_src valid
//   out_flit   : forwarded flit
//   out_src    : input index the forwarded flit came from
//   credit_in  : one-cycle pulse, downstream freed a slot
//   grant_active, err_credit_ovf, err_proto : status / sticky error flags
// modport master : the arbiter itself
// modport slave  : the FIFOs / downstream link around it
// ---------------------------------------------------------------------------
interface noc_out_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int FLIT_W = noc_pkg::FLIT_W
);
  localparam int SRC_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0]        in_empty;
  logic [N_IN*FLIT_W-1:0] in_flit;
  logic [N_IN-1:0]        in_rd_en;
  logic                   out_valid;
  logic [FLIT_W-1:0]      out_flit;
  logic [SRC_W-1:0]       out_src;
  logic                   credit_in;
  logic                   grant_active;
  logic                   err_credit_ovf;
  logic                   err_proto;

  modport master (
    input  in_empty, in_flit, credit_in,
    output in_rd_en, out_valid, out_flit, out_src,
           grant_active, err_credit_ovf, err_proto
  );

  modport slave (
    output in_empty, in_flit, credit_in,
    input  in_rd_en, out_valid, out_flit, out_src,
           grant_active, err_credit_ovf, err_proto
  );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way round-robin pick: the first asserted request at or
// after ptr, wrapping modulo N.
//   req   : request vector
//   ptr   : highest-priority index
//   gnt   : one-hot grant (all zero when no request)
//   valid : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  int j;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        gnt[j] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// ---------------------------------------------------------------------------
// noc_out_arbiter
// Wormhole output-port arbiter. Picks an input FIFO round-robin, then keeps
// popping that FIFO until the packet's tail has been forwarded. Reads are
// gated by downstream credits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : noc_out_arbiter_if.master (FIFO side, output link, status)
// Parameters:
//   N_IN     : number of competing input FIFOs
//   CREDITS  : initial credit count (usable downstream FIFO depth)
// ---------------------------------------------------------------------------
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int CREDITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_out_arbiter_if.master     bus
);

  localparam int SRC_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  arb_state_e        state_reg;
  logic [SRC_W-1:0]  rr_ptr_reg;
  logic [SRC_W-1:0]  lock_id_reg;
  logic [SRC_W-1:0]  src_q_reg;
  logic [CRD_W-1:0]  credits_reg;
  logic              out_valid_reg;
  logic              first_reg;      // next forwarded flit is the first of the grant
  logic              err_credit_ovf_reg;
  logic              err_proto_reg;

  logic [N_IN-1:0]   req;
  logic [N_IN-1:0]   arb_gnt;
  logic              arb_valid;
  logic [SRC_W-1:0]  arb_idx;
  logic [SRC_W-1:0]  rr_ptr_next;
  logic [N_IN-1:0]   rd_en;
  logic              rd_any;
  logic [SRC_W-1:0]  rd_idx;
  logic              have_credit;
  logic              release_now;
  logic [FLIT_W-1:0] cur_flit;
  flit_type_e        cur_type;
  logic [FLIT_W-1:0] flit_arr [N_IN];

  // Unflatten the FIFO data buses.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_slice
      assign flit_arr[gi] = bus.in_flit[gi*FLIT_W +: FLIT_W];
    end
  endgenerate

  assign req         = ~bus.in_empty;
  assign have_credit = (credits_reg != '0);

  rr_arbiter #(
    .N     (N_IN),
    .PTR_W (SRC_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (arb_gnt[i]) arb_idx = SRC_W'(i);
    end
  end

  assign rr_ptr_next = (arb_idx == SRC_W'(N_IN - 1)) ? '0 : arb_idx + SRC_W'(1);

  // Data of the FIFO popped last cycle is on its data_out bus now.
  assign cur_flit = flit_arr[src_q_reg];
  assign cur_type = flit_type(cur_flit);

  assign release_now = (state_reg == LOCKED) && out_valid_reg &&
                       (src_q_reg == lock_id_reg) &&
                       ((cur_type == TAIL) || (cur_type == HEAD_TAIL));

  // Read enables are combinational so a grant pops in the same cycle it is
  // decided. They are forced low during reset, and never issued on the
  // release cycle so the FIFO is not read past the tail.
  always_comb begin
    rd_en = '0;
    if (!rst) begin
      if (state_reg == IDLE) begin
        if (arb_valid && have_credit) rd_en = arb_gnt;
      end else if (!release_now && have_credit && !bus.in_empty[lock_id_reg]) begin
        rd_en[lock_id_reg] = 1'b1;
      end
    end
  end

  assign rd_any = |rd_en;
  assign rd_idx = (state_reg == IDLE) ? arb_idx : lock_id_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      rr_ptr_reg         <= '0;
      lock_id_reg        <= '0;
      src_q_reg          <= '0;
      credits_reg        <= CRD_MAX;
      out_valid_reg      <= 1'b0;
      first_reg          <= 1'b0;
      err_credit_ovf_reg <= 1'b0;
      err_proto_reg      <= 1'b0;
    end else begin
      out_valid_reg <= rd_any;
      if (rd_any) src_q_reg <= rd_idx;

      // Protocol monitor: only observes, never alters forwarding.
      if (out_valid_reg) begin
        first_reg <= 1'b0;
        if (first_reg && ((cur_type == BODY) || (cur_type == TAIL)))
          err_proto_reg <= 1'b1;
        if (!first_reg && ((cur_type == HEAD) || (cur_type == HEAD_TAIL)))
          err_proto_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (rd_any) begin
            lock_id_reg <= arb_idx;
            rr_ptr_reg  <= rr_ptr_next;
            first_reg   <= 1'b1;
            state_reg   <= LOCKED;
          end
        end
        LOCKED: begin
          if (release_now) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (bus.credit_in && (credits_reg == CRD_MAX)) err_credit_ovf_reg <= 1'b1;

      // A read and a returned credit in the same cycle cancel out.
      case ({rd_any, bus.credit_in})
        2'b10:   credits_reg <= credits_reg - CRD_W'(1);
        2'b01:   if (credits_reg != CRD_MAX) credits_reg <= credits_reg + CRD_W'(1);
        default: credits_reg <= credits_reg;
      endcase
    end
  end

  assign bus.in_rd_en       = rd_en;
  assign bus.out_valid      = out_valid_reg;
  assign bus.out_flit       = out_valid_reg ? cur_flit : '0;
  assign bus.out_src        = src_q_reg;
  assign bus.grant_active   = (state_reg == LOCKED);
  assign bus.err_credit_ovf = err_credit_ovf_reg;
  assign bus.err_proto      = err_proto_reg;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_out_arbiter
// Self-checking bench for noc_out_arbiter: FIFO models per input, an optional
// downstream credit-return model, and a scoreboard of expected output flits.
// ---------------------------------------------------------------------------
module tb_noc_out_arbiter;
  import noc_pkg::*;

  localparam int N_IN    = 4;
  localparam int CREDITS = 7;
  localparam int SRC_W   = 2;
  localparam int DEPTH   = 32;

  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [FLIT_W-1:0] flit;
  } exp_t;

  logic clk;
  logic rst;

  noc_out_arbiter_if #(.N_IN(N_IN), .FLIT_W(FLIT_W)) bus ();

  noc_out_arbiter #(
    .N_IN    (N_IN),
    .CREDITS (CREDITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t              sb[$];
  int                vtimes[$];
  logic [FLIT_W-1:0] fmem [N_IN][DEPTH];
  logic [FLIT_W-1:0] dout [N_IN];
  int                wp [N_IN];
  int                rp [N_IN];
  int                tb_credits;
  int                cyc;
  int                n_checks;
  int                n_fail;
  bit                auto_credit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FLIT_W-1:0] mk(input flit_type_e t, input int src, input int seq);
    logic [FLIT_W-3:0] pl;
    pl = (FLIT_W-2)'(src * 256 + seq);
    return {t, pl};
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < N_IN; i++) begin
      bus.in_flit[i*FLIT_W +: FLIT_W] = dout[i];
      bus.in_empty[i] = (wp[i] == rp[i]);
    end
  endtask

  task automatic push(input int i, input logic [FLIT_W-1:0] f);
    fmem[i][wp[i] % DEPTH] = f;
    wp[i] = wp[i] + 1;
    bus.in_empty[i] = 1'b0;
  endtask

  task automatic sb_push(input int i, input logic [FLIT_W-1:0] f);
    exp_t e;
    e.src  = SRC_W'(i);
    e.flit = f;
    sb.push_back(e);
  endtask

  // Advances one clock per iteration. At the falling edge the output link is
  // matched against the scoreboard and the read enables are checked against
  // the FIFO and credit models; FIFO pops take effect just after the rising edge.
  task automatic run_cycles(input int n);
    logic [N_IN-1:0] rd;
    logic [N_IN-1:0] emp;
    logic            ci;
    exp_t            e;
    int              t;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (auto_credit) bus.credit_in = bus.out_valid;
      rd = bus.in_rd_en;
      ci = bus.credit_in;
      for (int i = 0; i < N_IN; i++) emp[i] = (wp[i] == rp[i]);

      if (bus.out_valid === 1'b1) begin
        vtimes.push_back(cyc);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: cyc=%0d got src=%0d flit=%h, required no output",
                   cyc, bus.out_src, bus.out_flit);
        end else begin
          e = sb.pop_front();
          if (bus.out_src !== e.src || bus.out_flit !== e.flit) begin
            n_fail++;
            $display("FAIL sb_flit: cyc=%0d got src=%0d flit=%h, required src=%0d flit=%h",
                     cyc, bus.out_src, bus.out_flit, e.src, e.flit);
          end else begin
            $display("xfer cyc=%0d src=%0d flit=%h", cyc, bus.out_src, bus.out_flit);
          end
        end
      end

      n_checks++;
      if (((rd & emp) != '0) || ((rd != '0) && (tb_credits == 0)) || !$onehot0(rd)) begin
        n_fail++;
        $display("FAIL rd_guard: cyc=%0d in_rd_en=%b empty=%b credits=%0d, required one-hot read of non-empty FIFO with credit",
                 cyc, rd, emp, tb_credits);
      end

      t = tb_credits - ((rd != '0) ? 1 : 0) + (ci ? 1 : 0);
      if (t > CREDITS) t = CREDITS;
      tb_credits = t;

      for (int i = 0; i < N_IN; i++) begin
        if (rd[i] && (wp[i] != rp[i])) begin
          dout[i] = fmem[i][rp[i] % DEPTH];
          rp[i]   = rp[i] + 1;
        end
      end

      @(posedge clk);
      #1;
      drive_bus();
    end
  endtask

  task automatic pulse_credit();
    bus.credit_in = 1'b1;
    run_cycles(1);
    bus.credit_in = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    auto_credit = 1'b0;
    bus.credit_in = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      wp[i]   = 0;
      rp[i]   = 0;
      dout[i] = '0;
    end
    drive_bus();
    sb.delete();
    vtimes.delete();
    tb_credits = CREDITS;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [FLIT_W-1:0] f;
    f = mk(HEAD, 0, 0);
    push(0, f);
    #2;
    n_checks++;
    if ({bus.in_rd_en, bus.out_valid, bus.out_src, bus.grant_active,
         bus.err_credit_ovf, bus.err_proto} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd_en=%b valid=%b src=%0d grant=%b ovf=%b proto=%b, required all 0",
               bus.in_rd_en, bus.out_valid, bus.out_src, bus.grant_active,
               bus.err_credit_ovf, bus.err_proto);
    end
    apply_reset();
    run_cycles(2);
    n_checks++;
    if (bus.grant_active !== 1'b0 || dut.credits_reg !== 3'd7) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b credits=%0d, required grant=0 credits=7",
               bus.grant_active, dut.credits_reg);
    end
  endtask

  task automatic test_single_flit();
    logic [FLIT_W-1:0] f;
    apply_reset();
    f = mk(HEAD_TAIL, 2, 1);
    push(2, f);
    sb_push(2, f);
    #1;
    n_checks++;
    if (bus.in_rd_en !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_rd_en: got %b, required 0100", bus.in_rd_en);
    end
    run_cycles(1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.grant_active !== 1'b1) begin
      n_fail++;
      $display("FAIL single_out: valid=%b src=%0d grant=%b, required valid=1 src=2 grant=1",
               bus.out_valid, bus.out_src, bus.grant_active);
    end
    run_cycles(1);
    n_checks++;
    if (bus.grant_active !== 1'b0 || bus.in_rd_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: grant=%b rd_en=%b, required grant=0 rd_en=0000",
               bus.grant_active, bus.in_rd_en);
    end
    n_checks++;
    if (dut.credits_reg !== 3'd6) begin
      n_fail++;
      $display("FAIL single_credits: got %0d, required 6", dut.credits_reg);
    end
  endtask

  task automatic test_round_robin();
    int src_list[3] = '{0, 1, 3};
    int exp_off[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [FLIT_W-1:0] f;
    apply_reset();
    auto_credit = 1'b1;
    foreach (src_list[k]) begin
      f = mk(HEAD, src_list[k], 0); push(src_list[k], f); sb_push(src_list[k], f);
      f = mk(BODY, src_list[k], 1); push(src_list[k], f); sb_push(src_list[k], f);
      f = mk(TAIL, src_list[k], 2); push(src_list[k], f); sb_push(src_list[k], f);
    end
    run_cycles(16);
    n_checks++;
    if (vtimes.size() != 9) begin
      n_fail++;
      $display("FAIL rr_count: got %0d flits, required 9", vtimes.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_checks++;
        if (vtimes[k] - vtimes[0] != exp_off[k]) begin
          n_fail++;
          $display("FAIL rr_timing: flit %0d at offset %0d, required %0d",
                   k, vtimes[k] - vtimes[0], exp_off[k]);
        end
      end
    end
    n_checks++;
    if (dut.rr_ptr_reg !== 2'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rr_end: rr_ptr=%0d pending=%0d, required rr_ptr=0 pending=0",
               dut.rr_ptr_reg, sb.size());
    end
  endtask

  task automatic test_credit_stall();
    logic [FLIT_W-1:0] f;
    apply_reset();
    for (int s = 0; s < 10; s++) begin
      f = mk((s == 0) ? HEAD : ((s == 9) ? TAIL : BODY), 0, s);
      push(0, f);
      sb_push(0, f);
    end
    run_cycles(20);
    n_checks++;
    if (vtimes.size() != 7 || bus.in_rd_en !== 4'b0000 || bus.grant_active !== 1'b1) begin
      n_fail++;
      $display("FAIL stall: flits=%0d rd_en=%b grant=%b, required flits=7 rd_en=0000 grant=1",
               vtimes.size(), bus.in_rd_en, bus.grant_active);
    end
    n_checks++;
    if (dut.credits_reg !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_credits: got %0d, required 0", dut.credits_reg);
    end
    for (int k = 0; k < 3; k++) pulse_credit();
    run_cycles(4);
    n_checks++;
    if (vtimes.size() != 10 || bus.grant_active !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_resume: flits=%0d grant=%b pending=%0d, required flits=10 grant=0 pending=0",
               vtimes.size(), bus.grant_active, sb.size());
    end
  endtask

  task automatic test_mid_packet_empty();
    logic [FLIT_W-1:0] f_h1, f_b1, f_t1, f_ht0;
    apply_reset();
    auto_credit = 1'b1;
    f_h1  = mk(HEAD, 1, 0);
    f_b1  = mk(BODY, 1, 1);
    f_t1  = mk(TAIL, 1, 2);
    f_ht0 = mk(HEAD_TAIL, 0, 7);
    push(1, f_h1);
    sb_push(1, f_h1);
    run_cycles(2);
    push(0, f_ht0);
    for (int k = 0; k < 5; k++) begin
      run_cycles(1);
      n_checks++;
      if (bus.grant_active !== 1'b1 || bus.in_rd_en !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_grant: wait %0d grant=%b rd_en=%b, required grant=1 rd_en=0000",
                 k, bus.grant_active, bus.in_rd_en);
      end
    end
    push(1, f_b1);
    push(1, f_t1);
    sb_push(1, f_b1);
    sb_push(1, f_t1);
    sb_push(0, f_ht0);
    run_cycles(10);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL hold_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_credit_events();
    logic [FLIT_W-1:0] f;
    apply_reset();
    f = mk(HEAD_TAIL, 2, 3);
    push(2, f);
    sb_push(2, f);
    run_cycles(3);
    f = mk(HEAD_TAIL, 3, 4);
    push(3, f);
    sb_push(3, f);
    bus.credit_in = 1'b1;
    #1;
    n_checks++;
    if (bus.in_rd_en !== 4'b1000) begin
      n_fail++;
      $display("FAIL simul_rd: rd_en=%b, required 1000", bus.in_rd_en);
    end
    run_cycles(1);
    bus.credit_in = 1'b0;
    n_checks++;
    if (dut.credits_reg !== 3'd6 || bus.err_credit_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_credit: credits=%0d ovf=%b, required credits=6 ovf=0",
               dut.credits_reg, bus.err_credit_ovf);
    end
    run_cycles(2);
    pulse_credit();
    n_checks++;
    if (dut.credits_reg !== 3'd7 || bus.err_credit_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_refill: credits=%0d ovf=%b, required credits=7 ovf=0",
               dut.credits_reg, bus.err_credit_ovf);
    end
    pulse_credit();
    run_cycles(3);
    n_checks++;
    if (dut.credits_reg !== 3'd7 || bus.err_credit_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_ovf: credits=%0d ovf=%b, required credits=7 ovf=1",
               dut.credits_reg, bus.err_credit_ovf);
    end
  endtask

  task automatic test_reset_proto();
    logic [FLIT_W-1:0] f;
    apply_reset();
    auto_credit = 1'b1;
    for (int s = 0; s < 3; s++) begin
      f = mk((s == 0) ? HEAD : ((s == 2) ? TAIL : BODY), 0, s);
      push(0, f);
      sb_push(0, f);
    end
    run_cycles(2);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_rd_en, bus.out_valid, bus.out_src, bus.out_flit, bus.grant_active} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rd_en=%b valid=%b src=%0d flit=%h grant=%b, required all 0",
               bus.in_rd_en, bus.out_valid, bus.out_src, bus.out_flit, bus.grant_active);
    end
    apply_reset();
    n_checks++;
    if (dut.credits_reg !== 3'd7 || bus.err_proto !== 1'b0 || bus.err_credit_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: credits=%0d proto=%b ovf=%b, required credits=7 proto=0 ovf=0",
               dut.credits_reg, bus.err_proto, bus.err_credit_ovf);
    end
    run_cycles(4);
    n_checks++;
    if (bus.grant_active !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: grant=%b, required 0", bus.grant_active);
    end
    f = mk(BODY, 1, 5);
    push(1, f);
    sb_push(1, f);
    run_cycles(3);
    n_checks++;
    if (bus.err_proto !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL proto_err: err_proto=%b pending=%0d, required err_proto=1 pending=0",
               bus.err_proto, sb.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    auto_credit   = 1'b0;
    tb_credits    = CREDITS;
    bus.credit_in = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      wp[i]   = 0;
      rp[i]   = 0;
      dout[i] = '0;
    end
    drive_bus();

    test_reset();
    test_single_flit();
    test_round_robin();
    test_credit_stall();
    test_mid_packet_empty();
    test_credit_events();
    test_reset_proto();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
